// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
// Two-requester round-robin arbiter in front of a 2^ADDR_W x 8 word array.
// Every transaction uses the same four-cycle sequence: SETUP (address and data
// present, RW held at read), STROBE (RW drops only for a write), DONE (one-cycle
// ack to the owner), then back to IDLE.
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   a_req/a_rw/a_addr/a_wdata : requester A request (rw: 1 = read, 0 = write)
//   a_ack, a_rdata        : requester A completion pulse and last read data
//   b_*                   : same set of ports for requester B
//   mem_sel               : one-hot word select to the array
//   mem_rw                : array RW line (1 = read, 0 = write)
//   mem_wdata             : array write data
//   mem_rdata             : array read data from the selected word
//   busy                  : high whenever the controller is not idle
//
// All outputs are registers. Each one is loaded from a value worked out for the
// state the FSM is about to enter, so they line up with the state cycle by cycle.
module mem_arbiter_ctrl #(
  parameter  int ADDR_W  = 4,
  localparam int N_WORDS = 32'sd1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic               a_rw,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [7:0]         a_wdata,
  output logic               a_ack,
  output logic [7:0]         a_rdata,
  input  logic               b_req,
  input  logic               b_rw,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic [7:0]         b_wdata,
  output logic               b_ack,
  output logic [7:0]         b_rdata,
  output logic [N_WORDS-1:0] mem_sel,
  output logic               mem_rw,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transaction fields, frozen at grant
  logic              r_last_b;   // 1: B was granted last
  logic              r_owner_b;  // 1: current transaction belongs to B
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;

  // Grant decision and the fields the next state will use
  logic              w_gnt_valid;
  logic              w_gnt_b;
  logic              w_owner_b;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;

  // Next values of the registered outputs
  logic [N_WORDS-1:0] w_mem_sel;
  logic               w_mem_rw;
  logic [7:0]         w_mem_wdata;
  logic               w_a_ack;
  logic               w_b_ack;
  logic               w_busy;

  logic [N_WORDS-1:0] r_mem_sel;
  logic               r_mem_rw;
  logic [7:0]         r_mem_wdata;
  logic               r_a_ack;
  logic               r_b_ack;
  logic               r_busy;
  logic [7:0]         r_a_rdata;
  logic [7:0]         r_b_rdata;

  function automatic logic [N_WORDS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [N_WORDS-1:0] v;
    v       = {N_WORDS{1'b0}};
    v[addr] = 1'b1;
    return v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and round-robin grant (only meaningful in IDLE)
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_valid = (r_state == ST_IDLE) && (a_req || b_req);
    // B wins when alone, or on a tie when A was granted last
    w_gnt_b     = b_req && (!a_req || !r_last_b);
    if (w_gnt_valid) begin
      w_owner_b = w_gnt_b;
      w_rw      = w_gnt_b ? b_rw   : a_rw;
      w_addr    = w_gnt_b ? b_addr : a_addr;
    end else begin
      w_owner_b = r_owner_b;
      w_rw      = r_rw;
      w_addr    = r_addr;
    end
    case (r_state)
      ST_IDLE:   w_state_nxt = w_gnt_valid ? ST_SETUP : ST_IDLE;
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered
  always_comb begin
    w_mem_sel = {N_WORDS{1'b0}};
    w_mem_rw  = 1'b1;
    w_a_ack   = 1'b0;
    w_b_ack   = 1'b0;
    w_busy    = (w_state_nxt != ST_IDLE);
    if (w_gnt_valid) begin
      w_mem_wdata = w_gnt_b ? b_wdata : a_wdata;
    end else begin
      w_mem_wdata = r_mem_wdata;
    end
    case (w_state_nxt)
      ST_IDLE: begin
        w_mem_sel = {N_WORDS{1'b0}};
      end
      ST_SETUP: begin
        w_mem_sel = onehot(w_addr);
      end
      ST_STROBE: begin
        w_mem_sel = onehot(w_addr);
        w_mem_rw  = w_rw;   // the only place the RW line can go low
      end
      ST_DONE: begin
        w_a_ack = !w_owner_b;
        w_b_ack = w_owner_b;
      end
      default: begin
        w_mem_sel = {N_WORDS{1'b0}};
      end
    endcase
  end

  // Latch request fields and advance the round-robin pointer at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
      r_rw      <= 1'b1;
      r_addr    <= {ADDR_W{1'b0}};
    end else if (w_gnt_valid) begin
      r_last_b  <= w_gnt_b;
      r_owner_b <= w_gnt_b;
      r_rw      <= w_rw;
      r_addr    <= w_addr;
    end
  end

  // Registered array-side outputs, acks and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_sel   <= {N_WORDS{1'b0}};
      r_mem_rw    <= 1'b1;
      r_mem_wdata <= 8'h00;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_sel   <= w_mem_sel;
      r_mem_rw    <= w_mem_rw;
      r_mem_wdata <= w_mem_wdata;
      r_a_ack     <= w_a_ack;
      r_b_ack     <= w_b_ack;
      r_busy      <= w_busy;
    end
  end

  // Read data capture on the STROBE->DONE edge into the owner's register only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rdata <= 8'h00;
      r_b_rdata <= 8'h00;
    end else if ((r_state == ST_STROBE) && r_rw) begin
      if (r_owner_b) begin
        r_b_rdata <= mem_rdata;
      end else begin
        r_a_rdata <= mem_rdata;
      end
    end
  end

  assign mem_sel   = r_mem_sel;
  assign mem_rw    = r_mem_rw;
  assign mem_wdata = r_mem_wdata;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Testbench for mem_arbiter_ctrl: a word array driven by the DUT's select/RW
// lines, plus a transaction-timeline reference model with its own memory copy.
module tb_mem_arbiter_ctrl;
  localparam int ADDR_W  = 4;
  localparam int N_WORDS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               a_req, a_rw, b_req, b_rw;
  logic [ADDR_W-1:0]  a_addr, b_addr;
  logic [7:0]         a_wdata, b_wdata;
  logic               a_ack, b_ack, mem_rw, busy;
  logic [7:0]         a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [N_WORDS-1:0] mem_sel;

  mem_arbiter_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Physical array seen by the DUT
  logic [7:0] arr [N_WORDS];
  always_comb begin
    mem_rdata = 8'h00;
    for (int i = 0; i < N_WORDS; i++) begin
      if (mem_sel[i]) mem_rdata = mem_rdata | arr[i];
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline of edges since grant
  // (age 1 = SETUP, 2 = STROBE, 3 = DONE, leaves at 4).
  bit         m_active = 1'b0;
  int         m_age = 0;
  bit         m_who_b = 1'b0;
  bit         m_rw = 1'b1;
  logic [3:0] m_addr = 4'h0;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_mem_wdata = 8'h00;
  logic [7:0] m_a_rd = 8'h00;
  logic [7:0] m_b_rd = 8'h00;
  bit         m_last_b = 1'b1;
  logic [7:0] ref_mem [N_WORDS];
  int         wait_a = 0;
  int         wait_b = 0;

  task automatic model_advance();
    // a write has physically happened once STROBE completes, even under reset
    if (m_active && m_age == 2 && !m_rw) ref_mem[m_addr] = m_wd;
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_last_b = 1'b1;
      m_mem_wdata = 8'h00; m_a_rd = 8'h00; m_b_rd = 8'h00;
    end else if (m_active) begin
      if (m_age == 2 && m_rw) begin
        if (m_who_b) m_b_rd = ref_mem[m_addr];
        else         m_a_rd = ref_mem[m_addr];
      end
      m_age++;
      if (m_age == 4) m_active = 1'b0;
    end else if (a_req || b_req) begin
      m_who_b     = b_req && !(a_req && m_last_b);
      m_last_b    = m_who_b;
      m_rw        = m_who_b ? b_rw : a_rw;
      m_addr      = m_who_b ? b_addr : a_addr;
      m_wd        = m_who_b ? b_wdata : a_wdata;
      m_mem_wdata = m_wd;
      m_active    = 1'b1;
      m_age       = 1;
    end
    // consecutive edges each requester has been asking
    wait_a = (rst || !a_req) ? 0 : wait_a + 1;
    wait_b = (rst || !b_req) ? 0 : wait_b + 1;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_sel;
    exp_sel = (m_active && (m_age == 1 || m_age == 2)) ? (16'h0001 << m_addr) : 16'h0000;
    check_val("mem_sel", 32'(mem_sel), 32'(exp_sel));
    check_val("mem_rw", 32'(mem_rw), 32'(!(m_active && m_age == 2 && !m_rw)));
    check_val("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("a_ack", 32'(a_ack), 32'(m_active && m_age == 3 && !m_who_b));
    check_val("b_ack", 32'(b_ack), 32'(m_active && m_age == 3 && m_who_b));
    check_val("ack_excl", 32'(a_ack & b_ack), 32'd0);
    check_val("a_rdata", 32'(a_rdata), 32'(m_a_rd));
    check_val("b_rdata", 32'(b_rdata), 32'(m_b_rd));
    if (a_ack) begin
      check_val("a_wait_le8", 32'(wait_a <= 8), 32'd1);
      wait_a = 0;
    end
    if (b_ack) begin
      check_val("b_wait_le8", 32'(wait_b <= 8), 32'd1);
      wait_b = 0;
    end
    // the array commits whatever the DUT strobes
    if (mem_rw === 1'b0) begin
      for (int i = 0; i < N_WORDS; i++) if (mem_sel[i]) arr[i] = mem_wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_advance();
    check_outputs();
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; a_rw = 1'b1; b_rw = 1'b1;
    a_addr = 4'h0; b_addr = 4'h0; a_wdata = 8'h00; b_wdata = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < N_WORDS; i++) begin
      arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rw", 32'(mem_rw), 32'd1);
    rst = 1'b0;

    // A writes 0x5A to word 3; later changes of the fields must be ignored
    a_req = 1'b1; a_rw = 1'b0; a_addr = 4'd3; a_wdata = 8'h5A;
    step();
    check_val("wr_setup_sel", 32'(mem_sel), 32'h0008);
    check_val("wr_setup_rw", 32'(mem_rw), 32'd1);
    a_addr = 4'd7; a_wdata = 8'hFF;
    step();
    check_val("wr_strobe_sel", 32'(mem_sel), 32'h0008);
    check_val("wr_strobe_rw", 32'(mem_rw), 32'd0);
    check_val("wr_strobe_wd", 32'(mem_wdata), 32'h5A);
    step();
    check_val("wr_done_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    step();
    check_val("wr_idle_ack", 32'(a_ack), 32'd0);

    // A reads word 3 back
    a_req = 1'b1; a_rw = 1'b1; a_addr = 4'd3;
    step();
    step();
    check_val("rd_strobe_rw", 32'(mem_rw), 32'd1);
    step();
    check_val("rd_a_rdata", 32'(a_rdata), 32'h5A);
    check_val("rd_b_rdata", 32'(b_rdata), 32'h00);
    a_req = 1'b0;
    step();

    // Both requesting from reset: A, B, A, B four cycles apart
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_rw = 1'b1; b_rw = 1'b1; a_addr = 4'd1; b_addr = 4'd2;
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] exp_acks;
      step();
      exp_acks = (k % 8 == 3) ? 2'b10 : ((k % 8 == 7) ? 2'b01 : 2'b00);
      check_val("tie_seq", 32'({a_ack, b_ack}), 32'(exp_acks));
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) step();

    // B arrives while A is in SETUP: granted right after A's DONE
    a_req = 1'b1; a_rw = 1'b1; a_addr = 4'd4;
    step();
    b_req = 1'b1; b_rw = 1'b0; b_addr = 4'd9; b_wdata = 8'hC3;
    step();
    step();
    a_req = 1'b0;
    step();
    step();
    check_val("late_b_busy", 32'(busy), 32'd1);
    step();
    step();
    check_val("late_b_ack", 32'(b_ack), 32'd1);
    idle_inputs();
    step();

    // Reset during a write's SETUP: no strobe, no ack
    a_req = 1'b1; a_rw = 1'b0; a_addr = 4'd5; a_wdata = 8'h33;
    step();
    rst = 1'b1;
    step();
    check_val("abort_rw", 32'(mem_rw), 32'd1);
    check_val("abort_sel", 32'(mem_sel), 32'd0);
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 4; k++) step();

    // Random traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 149) == 0);
      a_req   = ($urandom_range(0, 99) < 55);
      b_req   = ($urandom_range(0, 99) < 55);
      a_rw    = $urandom_range(0, 1) == 1;
      b_rw    = $urandom_range(0, 1) == 1;
      a_addr  = 4'($urandom_range(0, 15));
      b_addr  = 4'($urandom_range(0, 15));
      a_wdata = 8'($urandom_range(0, 255));
      b_wdata = 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 5; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_ctrl.md
MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning word-address width; the array holds 2^ADDR_W words of 8 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port a_req  input  1  requester A transaction request.
REQ-006 Port a_rw  input  1  requester A direction: 1 = read, 0 = write.
REQ-007 Port a_addr  input  ADDR_W  requester A word address.
REQ-008 Port a_wdata  input  8  requester A write data.
REQ-009 Port a_ack  output  1  requester A completion pulse.
REQ-010 Port a_rdata  output  8  requester A last read data.
REQ-011 Ports b_req, b_rw, b_addr, b_wdata, b_ack and b_rdata SHALL mirror REQ-005..REQ-010 for requester B.
REQ-012 Port mem_sel  output  2^ADDR_W  one-hot word select to the array.
REQ-013 Port mem_rw  output  1  array RW line: 1 = read, 0 = write.
REQ-014 Port mem_wdata  output  8  array write data.
REQ-015 Port mem_rdata  input  8  array read data from the selected word.
REQ-016 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, STROBE and DONE, with transitions IDLE->SETUP (any req sampled high), SETUP->STROBE, STROBE->DONE and DONE->IDLE, all unconditional except the first.
REQ-018 In IDLE with exactly one req high, that requester SHALL be granted, and its rw, addr and wdata SHALL be latched on the same edge.
REQ-019 In IDLE with both reqs high, the requester not granted last SHALL win (round-robin).
REQ-020 After reset, the last-granted pointer SHALL be B, so A wins the first tie.
REQ-021 Request fields SHALL be sampled only at grant; changes after grant SHALL be ignored.
REQ-022 In SETUP, mem_sel SHALL be the one-hot decode of the latched address, mem_rw SHALL be 1, and mem_wdata SHALL be the latched wdata.
REQ-023 In STROBE, mem_sel and mem_wdata SHALL be unchanged from SETUP; mem_rw SHALL be 0 for a write and 1 for a read.
REQ-024 For a read, mem_rdata SHALL be captured into the granted requester's rdata on the STROBE->DONE edge.
REQ-025 The other requester's rdata, and any rdata on a write, SHALL hold its value.
REQ-026 In DONE, the granted requester's ack SHALL be 1 for exactly one cycle, mem_sel SHALL be all zeros and mem_rw SHALL be 1.
REQ-027 In IDLE, mem_sel SHALL be all zeros, mem_rw SHALL be 1 and mem_wdata SHALL hold its last value.
REQ-028 mem_rw SHALL be 0 only in STROBE of a write; no cell SHALL ever be written outside that cycle.
REQ-029 Latency SHALL be: req sampled at edge N, ack high in cycle N+3, next grant possible at edge N+4; each transaction SHALL take 4 cycles.
REQ-030 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-031 A requester that wants a single access SHALL drop req in the cycle it sees ack.
REQ-032 A non-granted req arriving while busy SHALL wait; it SHALL be neither lost nor acked early.
REQ-033 a_ack and b_ack SHALL never both be high.
REQ-034 Starvation bound: under continuous requests from both sides, the waiting requester SHALL be acked within 8 cycles of its req.

Reset
REQ-035 While rst is high at a clock edge, the state SHALL go to IDLE, with mem_sel=0, mem_rw=1, mem_wdata=0x00, a_ack=b_ack=0, a_rdata=b_rdata=0x00, busy=0 and the pointer at B.
REQ-036 A reset asserted mid-transaction SHALL abort it: no ack, no capture, and no write if asserted before the STROBE cycle.
REQ-037 Latched request fields are don't-care after reset.

Verification
REQ-038 Scenario: A write addr 3 data 0x5A -> mem_sel=0x0008 in cycles N+1..N+2, mem_rw=0 only in N+2, a_ack in N+3 only.
REQ-039 Scenario: A read addr 3 with model mem_rdata=0x5A -> mem_rw stays 1, a_rdata=0x5A from N+3, b_rdata unchanged.
REQ-040 Scenario: A and B both req'ing from reset, held high -> acks in order A, B, A, B, spaced 4 cycles apart.
REQ-041 Scenario: B req arrives while A's transaction is in SETUP -> B granted at the edge after A's DONE, b_ack 4 cycles later.
REQ-042 Scenario: rst pulsed during a write's SETUP -> no mem_rw=0 cycle, no ack, all outputs at reset values next cycle.
REQ-043 Scenario: random traffic with a scoreboard against a 16x8 model -> every read returns the last written value, and REQ-028 and REQ-033 are never violated.
